dequant_expand: RTL and testbench
=================================

Name: dequant_expand

Overview:
- Streaming dequantizer for the accelerator datapath. It takes 8-bit quantized activations and produces 16-bit values.
- Each value is sign- or zero-extended, then rescaled by a per-tensor shift.
- It is the inverse of the 16-to-8 requantizing shifter on the write side.
- It sits between the activation buffer read port and the 16-bit MAC input, and processes one tensor (cfg_len elements) per configuration.

Parameters:
- IN_W, 8, input element width
- OUT_W, 16, output element width; must be ≥ IN_W + 2^SHIFT_W − 1
- SHIFT_W, 3, shift-amount width (shift range 0..7)
- LEN_W, 16, element-count width

Ports:
- clk  in  1  sole clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready
- cfg_shift  in  SHIFT_W  shift amount for the tensor
- cfg_dir  in  1  1 = left shift (expand), 0 = right shift
- cfg_signed  in  1  1 = two's-complement input, 0 = unsigned
- cfg_len  in  LEN_W  number of elements in the tensor
- s_valid  in  1  input element valid
- s_ready  out  1  input element accepted when s_valid & s_ready
- s_data  in  IN_W  quantized input element
- m_valid  out  1  output element valid
- m_ready  in  1  downstream ready
- m_data  out  OUT_W  dequantized element
- m_last  out  1  asserted with the final element of the tensor
- busy  out  1  high while not in IDLE

Behaviour:
- **Reset:** state=IDLE. m_valid=0, m_data=0, m_last=0, busy=0, s_ready=0, cfg_ready=1 on the cycle after rst deasserts. Shift/dir/signed/count registers are cleared.
- **Reset mid-operation:** rst dominates every other input in the same cycle. Any in-flight output and the remaining count are discarded; no m_last is emitted.
- **FSM states:**
  - IDLE: cfg_ready=1, s_ready=0. A cfg handshake latches shift, dir, signed, len.
    - len≠0 → RUN, with remaining = len.
    - len=0 → stay IDLE; nothing is emitted.
  - RUN: cfg_ready=0. s_ready = (remaining≠0) & (!m_valid | m_ready).
    - Each input handshake decrements remaining.
    - When the handshake that takes remaining to 0 occurs → DRAIN.
  - DRAIN: s_ready=0. When m_valid & m_last & m_ready → IDLE. cfg_ready rises on the following cycle.
- **Datapath:**
  - ext = cfg_signed ? sign-extend(s_data) to OUT_W : zero-extend(s_data).
  - dir=1: m_data = ext << shift. This never overflows because OUT_W ≥ IN_W+7; no saturation logic.
  - dir=0, signed: arithmetic right shift. dir=0, unsigned: logical right shift. Truncation is toward −infinity; no rounding.
- **Latency and handshake:**
  - Single output register; latency is 1 cycle from input handshake to m_valid.
  - Throughput is 1 element/cycle when m_ready stays high.
  - m_valid/m_data/m_last hold stable while m_valid & !m_ready. No element is dropped or duplicated.
  - A simultaneous output handshake and new input handshake in the same cycle loads the next element; m_valid stays high.
- **m_last:** set on the element whose input handshake made remaining 0; cleared when that element transfers.
- **Config changes:** cfg inputs are ignored outside IDLE. Latched settings are not affected by cfg changes mid-tensor.

Test Plan:
1. signed=1, dir=1, shift=3, len=1, s_data=0x80 → m_data=0xFC00 one cycle later with m_last=1; busy drops and cfg_ready=1 the cycle after the transfer.
2. signed=0, dir=1, shift=7, len=2, data 0xFF, 0x01, m_ready=1 → 0x7F80, then 0x0080; m_last only on the 2nd; back-to-back, one per cycle.
3. signed=1, dir=0, shift=2, len=3, data 0x90, 0x7F, 0xFF → 0xFFE4, 0x001F, 0xFFFF. Repeat with signed=0 → 0x0024, 0x001F, 0x003F.
4. len=4 with m_ready toggling 1,0,0,1,0,1… → exactly 4 outputs, in order and stable while stalled. s_ready is low whenever m_valid & !m_ready. cfg_valid pulsed mid-tensor is not accepted.
5. len=0 config → no m_valid, state stays IDLE, cfg_ready remains 1. The next config with len=1 works normally.
6. len=5, rst asserted after 2 outputs with m_valid high → the next cycle has m_valid=0, busy=0, cfg_ready=1. A new config (len=1, 0x05, signed=0, dir=1, shift=0) yields 0x0005 with m_last=1.

Source files
------------

// File: rtl/dequant_expand.sv
// Streaming 8->16 bit dequantizer: sign/zero extension followed by a per-tensor
// left or right shift, one tensor of cfg_len elements per configuration.
module dequant_expand #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 3,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_dir,
    input  logic               cfg_signed,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [IN_W-1:0]    s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_data,
    output logic               m_last,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [SHIFT_W-1:0] shift_r;
    logic               dir_r;
    logic               signed_r;
    logic [LEN_W-1:0]   remaining;
    logic               cfg_fire, s_fire, m_fire;
    logic [OUT_W-1:0]   ext, result;

    assign cfg_fire = cfg_valid & cfg_ready;
    assign s_fire   = s_valid & s_ready;
    assign m_fire   = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_fire && cfg_len != '0) state_nxt = RUN;
            RUN:     if (s_fire && remaining == LEN_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (m_fire && m_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == IDLE);
        busy      = (state != IDLE);
        s_ready   = (state == RUN) && (remaining != '0) && (!m_valid || m_ready);
    end

    // A zero-length config still latches settings but never leaves IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r   <= '0;
            dir_r     <= 1'b0;
            signed_r  <= 1'b0;
            remaining <= '0;
        end else if (cfg_fire) begin
            shift_r   <= cfg_shift;
            dir_r     <= cfg_dir;
            signed_r  <= cfg_signed;
            remaining <= cfg_len;
        end else if (s_fire) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    always_comb begin
        ext = signed_r ? {{(OUT_W-IN_W){s_data[IN_W-1]}}, s_data}
                       : {{(OUT_W-IN_W){1'b0}}, s_data};
        if (dir_r)
            result = ext << shift_r;
        else if (signed_r)
            result = $unsigned($signed(ext) >>> shift_r);
        else
            result = ext >> shift_r;
    end

    // Single output stage: a new element may load in the same cycle the old one leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (s_fire) begin
            m_valid <= 1'b1;
            m_data  <= result;
            m_last  <= (remaining == LEN_W'(1));
        end else if (m_fire) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dequant_expand.sv
// Self-checking bench for dequant_expand: directed vectors plus randomized
// tensors checked against an arithmetic reference model.
module tb_dequant_expand;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready;
    logic [2:0]  cfg_shift;
    logic        cfg_dir, cfg_signed;
    logic [15:0] cfg_len;
    logic        s_valid, s_ready;
    logic [7:0]  s_data;
    logic        m_valid, m_ready;
    logic [15:0] m_data;
    logic        m_last, busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef logic [7:0]  dq_t[$];
    typedef logic [15:0] oq_t[$];
    typedef int          iq_t[$];
    typedef bit          bq_t[$];

    dequant_expand dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_shift(cfg_shift),
        .cfg_dir(cfg_dir), .cfg_signed(cfg_signed), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Value = input interpreted as integer, times 2^shift or floor-divided by 2^shift.
    function automatic logic [15:0] ref_val(int shift, int dir, int sgn, logic [7:0] d);
        int v, p, q;
        v = int'(d);
        if (sgn != 0 && d[7]) v = v - 256;
        p = 1 << shift;
        if (dir != 0) q = v * p;
        else begin
            q = v / p;
            if ((v % p) != 0 && v < 0) q = q - 1;
        end
        return q[15:0];
    endfunction

    // rmode: 0 always ready, 1 pattern 1,0,0,1,0,1, 2 random. vmode: 0 dense, 1 gappy.
    // viol counts protocol breaches: stall instability, s_ready under stall, cfg accepted mid-tensor.
    task automatic run_tensor(input int shift, input int dir, input int sgn, input int len,
                              input dq_t din, input int rmode, input int vmode, input bit poke,
                              output oq_t dout, output bq_t lout, output iq_t ocyc,
                              output int viol, output int lat);
        int sent, got, cyc, first_in, first_v;
        bit stall, hl;
        logic [15:0] hd;
        logic [5:0] pat;
        pat = 6'b101001;
        viol = 0; sent = 0; got = 0; cyc = 0; first_in = -1; first_v = -1;
        stall = 0; hl = 0; hd = '0;
        dout.delete(); lout.delete(); ocyc.delete();
        @(negedge clk);
        cfg_shift = 3'(shift); cfg_dir = dir[0]; cfg_signed = sgn[0]; cfg_len = 16'(len);
        cfg_valid = 1'b1;
        #1 if (!cfg_ready) viol++;
        @(posedge clk);
        while (got < len && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            cfg_valid = 1'b0;
            if (poke && (cyc % 3) == 0) begin
                cfg_valid = 1'b1; cfg_len = 16'd1;
                cfg_shift = 3'($urandom); cfg_dir = 1'($urandom); cfg_signed = 1'($urandom);
            end
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[(cyc-1) % 6];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            s_valid = (sent < len) && (vmode == 0 || $urandom_range(0, 3) != 0);
            s_data  = s_valid ? din[sent] : 8'($urandom);
            #1;
            if (cfg_valid && cfg_ready) viol++;
            if (stall && (!m_valid || m_data !== hd || m_last !== hl)) viol++;
            if (m_valid && !m_ready && s_ready) viol++;
            if (m_valid && first_v < 0) first_v = cyc;
            if (s_valid && s_ready) begin
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            if (m_valid && m_ready) begin
                dout.push_back(m_data); lout.push_back(m_last); ocyc.push_back(cyc);
                got++;
            end
            stall = m_valid && !m_ready; hd = m_data; hl = m_last;
        end
        s_valid = 1'b0;
        cfg_valid = 1'b0;
        lat = first_v - first_in;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 16'h0)   begin n_err++; $display("FAIL reset_m_data got %h want 0000", m_data); end
        n_cmp++; if (m_last !== 1'b0)    begin n_err++; $display("FAIL reset_m_last got %b want 0", m_last); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (s_ready !== 1'b0)   begin n_err++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    endtask

    // Hand-computed vectors: signed expand, unsigned expand, signed/unsigned right shift.
    task automatic test_directed();
        int shift, dir, sgn, len, viol, lat;
        dq_t din; oq_t dout; bq_t lout; iq_t ocyc;
        logic [15:0] exp_v[3];
        for (int t = 0; t < 4; t++) begin
            din.delete();
            case (t)
                0: begin shift = 3; dir = 1; sgn = 1; len = 1; din.push_back(8'h80);
                         exp_v[0] = 16'hFC00; exp_v[1] = 16'h0; exp_v[2] = 16'h0; end
                1: begin shift = 7; dir = 1; sgn = 0; len = 2; din.push_back(8'hFF); din.push_back(8'h01);
                         exp_v[0] = 16'h7F80; exp_v[1] = 16'h0080; exp_v[2] = 16'h0; end
                2: begin shift = 2; dir = 0; sgn = 1; len = 3;
                         din.push_back(8'h90); din.push_back(8'h7F); din.push_back(8'hFF);
                         exp_v[0] = 16'hFFE4; exp_v[1] = 16'h001F; exp_v[2] = 16'hFFFF; end
                default: begin shift = 2; dir = 0; sgn = 0; len = 3;
                         din.push_back(8'h90); din.push_back(8'h7F); din.push_back(8'hFF);
                         exp_v[0] = 16'h0024; exp_v[1] = 16'h001F; exp_v[2] = 16'h003F; end
            endcase
            run_tensor(shift, dir, sgn, len, din, 0, 0, 1'b0, dout, lout, ocyc, viol, lat);
            n_cmp++; if (dout.size() != len) begin n_err++; $display("FAIL dir%0d_count got %0d want %0d", t, dout.size(), len); end
            n_cmp++; if (lat != 1) begin n_err++; $display("FAIL dir%0d_latency got %0d want 1", t, lat); end
            n_cmp++; if (viol != 0) begin n_err++; $display("FAIL dir%0d_protocol got %0d want 0", t, viol); end
            for (int i = 0; i < dout.size() && i < 3; i++) begin
                n_cmp++; if (dout[i] !== exp_v[i]) begin n_err++; $display("FAIL dir%0d_data[%0d] got %h want %h", t, i, dout[i], exp_v[i]); end
                n_cmp++; if (lout[i] !== (i == len-1)) begin n_err++; $display("FAIL dir%0d_last[%0d] got %b want %b", t, i, lout[i], (i == len-1)); end
                if (i > 0) begin
                    n_cmp++; if (ocyc[i] - ocyc[i-1] != 1) begin n_err++; $display("FAIL dir%0d_b2b[%0d] got gap %0d want 1", t, i, ocyc[i]-ocyc[i-1]); end
                end
            end
            n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL dir%0d_busy_after got %b want 0", t, busy); end
            n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_cfg_ready_after got %b want 1", t, cfg_ready); end
        end
    endtask

    task automatic test_stall();
        int shift, dir, sgn, viol, lat;
        dq_t din; oq_t dout; bq_t lout; iq_t ocyc;
        shift = $urandom_range(0, 7); dir = $urandom_range(0, 1); sgn = $urandom_range(0, 1);
        for (int i = 0; i < 4; i++) din.push_back(8'($urandom));
        run_tensor(shift, dir, sgn, 4, din, 1, 0, 1'b1, dout, lout, ocyc, viol, lat);
        n_cmp++; if (dout.size() != 4) begin n_err++; $display("FAIL stall_count got %0d want 4", dout.size()); end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL stall_protocol got %0d want 0", viol); end
        for (int i = 0; i < dout.size(); i++) begin
            n_cmp++; if (dout[i] !== ref_val(shift, dir, sgn, din[i]))
                begin n_err++; $display("FAIL stall_data[%0d] got %h want %h", i, dout[i], ref_val(shift, dir, sgn, din[i])); end
            n_cmp++; if (lout[i] !== (i == 3)) begin n_err++; $display("FAIL stall_last[%0d] got %b want %b", i, lout[i], (i == 3)); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_busy_after got %b want 0", busy); end
    endtask

    task automatic test_zero_len();
        int viol, lat;
        dq_t din; oq_t dout; bq_t lout; iq_t ocyc;
        logic [7:0] d;
        @(negedge clk);
        cfg_shift = 3'd1; cfg_dir = 1'b1; cfg_signed = 1'b0; cfg_len = 16'd0; cfg_valid = 1'b1;
        @(posedge clk);
        @(negedge clk) cfg_valid = 1'b0; s_valid = 1'b1; s_data = 8'h33;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL zlen_m_valid[%0d] got %b want 0", i, m_valid); end
            n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL zlen_busy[%0d] got %b want 0", i, busy); end
            n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL zlen_cfg_ready[%0d] got %b want 1", i, cfg_ready); end
            n_cmp++; if (s_ready !== 1'b0)   begin n_err++; $display("FAIL zlen_s_ready[%0d] got %b want 0", i, s_ready); end
            @(negedge clk);
        end
        s_valid = 1'b0;
        d = 8'($urandom);
        din.push_back(d);
        run_tensor(4, 0, 1, 1, din, 0, 0, 1'b0, dout, lout, ocyc, viol, lat);
        n_cmp++; if (dout.size() != 1) begin n_err++; $display("FAIL zlen_next_count got %0d want 1", dout.size()); end
        else begin
            n_cmp++; if (dout[0] !== ref_val(4, 0, 1, d)) begin n_err++; $display("FAIL zlen_next_data got %h want %h", dout[0], ref_val(4, 0, 1, d)); end
            n_cmp++; if (lout[0] !== 1'b1) begin n_err++; $display("FAIL zlen_next_last got %b want 1", lout[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int got, cyc, viol, lat;
        dq_t din; oq_t dout; bq_t lout; iq_t ocyc;
        bit fired;
        @(negedge clk);
        cfg_shift = 3'd0; cfg_dir = 1'b1; cfg_signed = 1'b0; cfg_len = 16'd5; cfg_valid = 1'b1;
        @(posedge clk);
        got = 0; cyc = 0; fired = 0;
        while (!fired && cyc < 100) begin
            @(negedge clk);
            cyc++;
            cfg_valid = 1'b0; m_ready = 1'b1; s_valid = 1'b1; s_data = 8'($urandom);
            #1;
            if (got == 2 && m_valid) begin
                rst = 1'b1; fired = 1;
            end else if (m_valid && m_ready) got++;
        end
        n_cmp++; if (!fired) begin n_err++; $display("FAIL rmid_reached got %0d outputs want 2", got); end
        @(posedge clk);
        @(negedge clk) rst = 1'b0; s_valid = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0)   begin n_err++; $display("FAIL rmid_m_valid got %b want 0", m_valid); end
        n_cmp++; if (m_last !== 1'b0)    begin n_err++; $display("FAIL rmid_m_last got %b want 0", m_last); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rmid_cfg_ready got %b want 1", cfg_ready); end
        din.push_back(8'h05);
        run_tensor(0, 1, 0, 1, din, 0, 0, 1'b0, dout, lout, ocyc, viol, lat);
        n_cmp++; if (dout.size() != 1) begin n_err++; $display("FAIL rmid_next_count got %0d want 1", dout.size()); end
        else begin
            n_cmp++; if (dout[0] !== 16'h0005) begin n_err++; $display("FAIL rmid_next_data got %h want 0005", dout[0]); end
            n_cmp++; if (lout[0] !== 1'b1) begin n_err++; $display("FAIL rmid_next_last got %b want 1", lout[0]); end
        end
    endtask

    task automatic test_random();
        int shift, dir, sgn, len, viol, lat;
        dq_t din; oq_t dout; bq_t lout; iq_t ocyc;
        for (int t = 0; t < 8; t++) begin
            shift = $urandom_range(0, 7); dir = $urandom_range(0, 1); sgn = $urandom_range(0, 1);
            len = $urandom_range(1, 12);
            din.delete();
            for (int i = 0; i < len; i++) din.push_back(8'($urandom));
            run_tensor(shift, dir, sgn, len, din, 2, 1, 1'b1, dout, lout, ocyc, viol, lat);
            n_cmp++; if (dout.size() != len) begin n_err++; $display("FAIL rnd%0d_count got %0d want %0d", t, dout.size(), len); end
            n_cmp++; if (viol != 0) begin n_err++; $display("FAIL rnd%0d_protocol got %0d want 0", t, viol); end
            for (int i = 0; i < dout.size(); i++) begin
                n_cmp++; if (dout[i] !== ref_val(shift, dir, sgn, din[i]))
                    begin n_err++; $display("FAIL rnd%0d_data[%0d] got %h want %h", t, i, dout[i], ref_val(shift, dir, sgn, din[i])); end
                n_cmp++; if (lout[i] !== (i == len-1)) begin n_err++; $display("FAIL rnd%0d_last[%0d] got %b want %b", t, i, lout[i], (i == len-1)); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_shift = '0; cfg_dir = 1'b0; cfg_signed = 1'b0;
        cfg_len = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
